// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if;
    logic        req0;
    logic        rw0;
    logic [15:0] addr0;
    logic [15:0] wdata0;
    logic        gnt0;
    logic        stall0;
    logic        rvalid0;

    logic        req1;
    logic        rw1;
    logic [15:0] addr1;
    logic [15:0] wdata1;
    logic        lock1;
    logic        gnt1;
    logic        rvalid1;

    logic [15:0] rdata;

    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    modport slave (
        input  req0, rw0, addr0, wdata0,
        output gnt0, stall0, rvalid0,
        input  req1, rw1, addr1, wdata1, lock1,
        output gnt1, rvalid1,
        output rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output req0, rw0, addr0, wdata0,
        input  gnt0, stall0, rvalid0,
        output req1, rw1, addr1, wdata1, lock1,
        input  gnt1, rvalid1,
        input  rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 fixed priority, port 1
// anti-starvation and burst lock. Define DMEM_ARB_STATS_EN to add activity counters.
//
// state   | meaning
// ARB     | normal arbitration, port 0 wins unless port 1 has starved MAX_WAIT cycles
// P1_LOCK | port 1 owns the memory for a burst; port 0 only gets idle cycles
module dmem_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]         conflict_cnt,
    output logic [15:0]         force_cnt,
    output logic [15:0]         stall_cnt
`endif
);

    typedef enum logic {
        ARB     = 1'b0,
        P1_LOCK = 1'b1
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              force1;
    logic              gnt0;
    logic              gnt1;
    logic              rd_pend0;
    logic              rd_pend1;

    assign force1 = (wait_cnt == MAX_WAIT_C);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants stay combinational so a granted access hits the memory in the same cycle.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        if (reset) begin
            case (state)
                ARB: begin
                    gnt1 = bus.req1 & (force1 | ~bus.req0);
                    gnt0 = bus.req0 & ~gnt1;
                    if (gnt1 & bus.lock1) begin
                        state_nxt = P1_LOCK;
                    end
                end
                P1_LOCK: begin
                    gnt1 = bus.req1;
                    gnt0 = bus.req0 & ~bus.req1;
                    if (!(bus.req1 & bus.lock1)) begin
                        state_nxt = ARB;
                    end
                end
                default: begin
                    state_nxt = ARB;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (gnt1 || !bus.req1) begin
            wait_cnt <= '0;
        end else if (wait_cnt < MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            rd_pend0 <= gnt0 & ~bus.rw0;
            rd_pend1 <= gnt1 & ~bus.rw1;
        end
    end

    always_comb begin
        bus.mem_en   = gnt0 | gnt1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        if (gnt1) begin
            bus.mem_we   = bus.rw1;
            bus.mem_addr = bus.addr1;
            bus.mem_din  = bus.wdata1;
        end else if (gnt0) begin
            bus.mem_we   = bus.rw0;
            bus.mem_addr = bus.addr0;
            bus.mem_din  = bus.wdata0;
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.stall0  = bus.req0 & ~gnt0;
    assign bus.rvalid0 = rd_pend0;
    assign bus.rvalid1 = rd_pend1;
    assign bus.rdata   = bus.mem_dout;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt <= '0;
            force_cnt    <= '0;
            stall_cnt    <= '0;
        end else begin
            if (bus.req0 && bus.req1) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (force1 && gnt1) begin
                force_cnt <= force_cnt + 16'd1;
            end
            if (bus.req0 && !gnt0) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory behind it.
module tb_dmem_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   passed;
    logic [15:0] mem [0:255];

    dmem_arbiter_if bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [15:0] force_cnt;
    logic [15:0] stall_cnt;
`endif

    dmem_arbiter #(.MAX_WAIT(8), .WAIT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .force_cnt    (force_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_din;
            else            bus.mem_dout <= mem[bus.mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.addr0 = 16'h0; bus.wdata0 = 16'h0;
        bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.addr1 = 16'h0; bus.wdata1 = 16'h0;
        bus.lock1 = 1'b0;
        bus.mem_dout = 16'h0;

        // Reset: grants forced off, stall follows req0
        tick();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        settle();
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_gnt1", bus.gnt1, 0);
        check("rst_stall0", bus.stall0, 1);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_rvalid0", bus.rvalid0, 0);
        check("rst_rvalid1", bus.rvalid1, 0);
        tick();
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Port 0 write then read of the same word
        tick();
        bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 16'h0010; bus.wdata0 = 16'hBEEF;
        settle();
        check("wr_gnt0", bus.gnt0, 1);
        check("wr_mem_we", bus.mem_we, 1);
        check("wr_mem_addr", bus.mem_addr, 16'h0010);
        check("wr_mem_din", bus.mem_din, 16'hBEEF);
        tick();
        bus.rw0 = 1'b0;
        settle();
        check("rd_gnt0", bus.gnt0, 1);
        check("rd_mem_we", bus.mem_we, 0);
        check("wr_no_rvalid0", bus.rvalid0, 0);
        tick();
        bus.req0 = 1'b0; bus.addr0 = 16'h0055; bus.wdata0 = 16'h1234;
        settle();
        check("rd_rvalid0", bus.rvalid0, 1);
        check("rd_rdata", bus.rdata, 16'hBEEF);
        check("rd_rvalid1", bus.rvalid1, 0);

        // Idle memory
        tick();
        settle();
        check("idle_rvalid0", bus.rvalid0, 0);
        check("idle_mem_en", bus.mem_en, 0);
        check("idle_mem_addr", bus.mem_addr, 0);
        check("idle_mem_din", bus.mem_din, 0);
        check("idle_wait_cnt", dut.wait_cnt, 0);

        // Starvation: port 1 forced through every 9th cycle
        tick();
        bus.req0 = 1'b1; bus.rw0 = 1'b1;
        bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 16'h0200; bus.wdata1 = 16'h00AA;
        for (int c = 0; c < 18; c++) begin
            logic exp1;
            exp1 = ((c % 9) == 8);
            settle();
            check($sformatf("starve_gnt0_c%0d", c), bus.gnt0, !exp1);
            check($sformatf("starve_gnt1_c%0d", c), bus.gnt1, exp1);
            check($sformatf("starve_stall0_c%0d", c), bus.stall0, exp1);
            if (exp1) check($sformatf("starve_addr_c%0d", c), bus.mem_addr, 16'h0200);
            tick();
        end
        check("starve_wait_cleared", dut.wait_cnt, 0);
`ifdef DMEM_ARB_STATS_EN
        check("stats_conflict", conflict_cnt, 18);
        check("stats_force", force_cnt, 2);
        check("stats_stall", stall_cnt, 2);
`endif
        tick(); tick(); tick();
        check("wait_cnt_3", dut.wait_cnt, 3);
        bus.req1 = 1'b0;
        tick();
        check("wait_cnt_clear_noreq", dut.wait_cnt, 0);

        // Burst lock entered on a forced grant, held 4 beats
        bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.addr1 = 16'h0100;
        for (int c = 0; c < 8; c++) begin
            settle();
            check($sformatf("burst_pre_gnt0_c%0d", c), bus.gnt0, 1);
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            bus.addr1 = 16'h0100 + 16'(b);
            if (b == 3) bus.lock1 = 1'b0;
            settle();
            check($sformatf("burst_gnt1_b%0d", b), bus.gnt1, 1);
            check($sformatf("burst_stall0_b%0d", b), bus.stall0, 1);
            check($sformatf("burst_addr_b%0d", b), bus.mem_addr, 16'h0100 + 32'(b));
            if (b > 0) check($sformatf("burst_state_b%0d", b), dut.state, 1);
            tick();
        end
        bus.req1 = 1'b0;
        settle();
        check("burst_end_state", dut.state, 0);
        check("burst_end_gnt0", bus.gnt0, 1);
        check("burst_end_stall0", bus.stall0, 0);

        // In P1_LOCK an idle port 1 hands the cycle to port 0 and unlocks
        tick();
        bus.req0 = 1'b0; bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.rw1 = 1'b1;
        settle();
        check("lock_entry_gnt1", bus.gnt1, 1);
        tick();
        bus.req0 = 1'b1; bus.req1 = 1'b0;
        settle();
        check("lock_idle_state", dut.state, 1);
        check("lock_idle_gnt0", bus.gnt0, 1);
        check("lock_idle_gnt1", bus.gnt1, 0);
        tick();
        check("lock_idle_exit", dut.state, 0);

        // Reset while a port 1 read is granted inside a burst
        bus.req0 = 1'b0; bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 16'h0010;
        tick();
        settle();
        check("rst_mid_state_lock", dut.state, 1);
        check("rst_mid_gnt1", bus.gnt1, 1);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_gnt1_forced", bus.gnt1, 0);
        tick();
        settle();
        check("rst_mid_rvalid1", bus.rvalid1, 0);
        check("rst_mid_state", dut.state, 0);
        check("rst_mid_wait", dut.wait_cnt, 0);
        tick();
        reset = 1'b1;
        bus.req1 = 1'b0; bus.lock1 = 1'b0;
        bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 16'h0010;
        settle();
        check("post_rst_gnt0", bus.gnt0, 1);
        tick();
        bus.req0 = 1'b0;
        settle();
        check("post_rst_rvalid0", bus.rvalid0, 1);
        check("post_rst_rdata", bus.rdata, 16'hBEEF);
        check("post_rst_rvalid1", bus.rvalid1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
